ahb5_apb4_bridge: RTL

// Single-port AHB5 slave to APB4 master bridge, one outstanding transfer. Sits downstream of the random AHB5 transaction generator.

---
 rtl/ahb5_apb4_bridge_if.sv | 50 +++++
 rtl/ahb5_apb4_bridge.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ahb5_apb4_bridge_if.sv
// Bus bundle between an AHB5 manager and an APB4 completer, bridged by
// ahb5_apb4_bridge.
//   slave  : bridge view (AHB slave side in, APB master side out)
//   master : environment view (drives AHB requests, answers APB)
// Signals: HSEL HADDR HTRANS HWRITE HSIZE HPROT HNONSEC HCID HWDATA HREADY
//          HREADYOUT HRDATA HRESP PADDR PSEL PENABLE PWRITE PWDATA PSTRB
//          PRDATA PREADY PSLVERROR
interface ahb5_apb4_bridge_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [3:0]    HPROT;
  logic          HNONSEC;
  logic [3:0]    HCID;
  logic [DW-1:0] HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic [DW-1:0] HRDATA;
  logic          HRESP;

  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERROR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HNONSEC, HCID, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERROR
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HNONSEC, HCID, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERROR
  );
endinterface

// File: rtl/ahb5_apb4_bridge.sv
// AHB5 slave to APB4 master bridge with one outstanding transfer. Checks
// privilege, compartment-ID and security policy plus size/alignment before
// forwarding; rejected accesses get a two-cycle AHB ERROR and never reach APB.
// Ports:
//   HCLK, HRESETn   clock, synchronous active-low reset
//   bus             ahb5_apb4_bridge_if.slave (AHB slave + APB master signals)
//   ilac_priv/cid/sec  illegal-access flags, high during a policy ERROR
module ahb5_apb4_bridge #(
  parameter bit         PRIV_ONLY  = 1'b1,
  parameter bit         SEC_ONLY   = 1'b1,
  parameter bit         CID_CHK_EN = 1'b1,
  parameter logic [3:0] CID_VAL    = 4'h0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  ahb5_apb4_bridge_if.slave      bus,
  output logic                   ilac_priv,
  output logic                   ilac_cid,
  output logic                   ilac_sec
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  typedef enum logic [2:0] {IDLE, WDAT, SETUP, ACCESS, ERR1, ERR2} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [1:0]    size_q;
  logic [2:0]    pol_q, pol_d;     // {priv, cid, sec} of the current transfer

  logic          accept;
  logic          v_priv, v_sec, v_cid, fmt_err;
  logic [SW-1:0] strb;
  logic          hreadyout_d, hresp_d, psel_d, penable_d;
  logic [2:0]    ilac_d;

  logic          unused_prot;
  assign unused_prot = ^{bus.HPROT[3:2], bus.HPROT[0]};

  // Address-phase qualification and access policy
  assign accept  = (state_q == IDLE) && bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign v_priv  = PRIV_ONLY  && !bus.HPROT[1];
  assign v_sec   = SEC_ONLY   && bus.HNONSEC;
  assign v_cid   = CID_CHK_EN && (bus.HCID != CID_VAL);
  assign fmt_err = (bus.HSIZE > 3'd2) ||
                   ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
                   ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));

  // Byte lanes of the latched transfer; reads carry no strobes
  always_comb begin
    strb = '0;
    if (write_q) begin
      case (size_q)
        2'd0:    strb = SW'(4'b0001 << addr_q[1:0]);
        2'd1:    strb = SW'(4'b0011 << {addr_q[1], 1'b0});
        default: strb = 4'b1111;
      endcase
    end
  end

  // Next state and next registered output values
  always_comb begin
    state_d = state_q;
    pol_d   = pol_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pol_d   = {v_priv, v_cid, v_sec};
          state_d = (v_priv || v_cid || v_sec || fmt_err) ? ERR1 : WDAT;
        end
      end
      WDAT:   state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (bus.PREADY) begin
          state_d = bus.PSLVERROR ? ERR1 : IDLE;
          pol_d   = 3'b000;
        end
      end
      ERR1:    state_d = ERR2;
      ERR2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    hreadyout_d = (state_d == IDLE) || (state_d == ERR2);
    hresp_d     = (state_d == ERR1) || (state_d == ERR2);
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    ilac_d      = hresp_d ? pol_d : 3'b000;
  end

  // State, latched transfer and registered outputs
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      write_q       <= 1'b0;
      size_q        <= '0;
      pol_q         <= '0;
      bus.HREADYOUT <= 1'b1;
      bus.HRESP     <= 1'b0;
      bus.HRDATA    <= '0;
      bus.PADDR     <= '0;
      bus.PSEL      <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PWDATA    <= '0;
      bus.PSTRB     <= '0;
      ilac_priv     <= 1'b0;
      ilac_cid      <= 1'b0;
      ilac_sec      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pol_q         <= pol_d;
      bus.HREADYOUT <= hreadyout_d;
      bus.HRESP     <= hresp_d;
      bus.PSEL      <= psel_d;
      bus.PENABLE   <= penable_d;
      {ilac_priv, ilac_cid, ilac_sec} <= ilac_d;

      if (accept) begin
        addr_q  <= bus.HADDR;
        write_q <= bus.HWRITE;
        size_q  <= bus.HSIZE[1:0];
      end

      // Data phase: load APB request so it is stable from SETUP to ACCESS end
      if (state_q == WDAT) begin
        bus.PADDR  <= addr_q;
        bus.PWRITE <= write_q;
        bus.PSTRB  <= strb;
        if (write_q) bus.PWDATA <= bus.HWDATA;
      end

      if ((state_q == ACCESS) && bus.PREADY && !bus.PSLVERROR && !write_q)
        bus.HRDATA <= bus.PRDATA;
    end
  end
endmodule
